pc_branch_ctrl: RTL
===================

PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall_if  input  1  IF held this cycle; PC must not advance.
REQ-005 id_fire  input  1  instruction in ID leaves ID this cycle (valid and not stalled).
REQ-006 flush  input  1  exception/ERET redirect request.
REQ-007 redirect_pc  input  32  target PC when flush=1.
REQ-008 id_op  input  6  opcode of ID instruction.
REQ-009 id_rt  input  5  rt field (REGIMM subtype).
REQ-010 id_rd  input  5  rd field (JALR link register).
REQ-011 id_funct  input  6  funct field (SPECIAL).
REQ-012 id_imm  input  16  branch offset.
REQ-013 id_index  input  26  J/JAL instruction index.
REQ-014 id_pc  input  32  PC of ID instruction.
REQ-015 rs_val  input  32  forwarded rs value (JR/JALR target).
REQ-016 cmp_taken  input  1  branch condition result from ID comparator, valid same cycle.
REQ-017 pc  output  32  current fetch PC (registered).
REQ-018 pc_adel  output  1  pc[1:0]!=0, combinational from pc.
REQ-019 br_taken  output  1  combinational: id_fire and control transfer taken this cycle.
REQ-020 link_wen  output  1  combinational: id_fire and linking instruction.
REQ-021 link_reg  output  5  31 for JAL/BLTZAL/BGEZAL; id_rd for JALR.
REQ-022 link_addr  output  32  id_pc+8.
REQ-023 next_in_ds  output  1  registered: instruction entering ID next is a delay slot.

Function
REQ-024 Control instructions decoded: BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, REGIMM 000001 with rt BLTZ 00000/BGEZ 00001/BLTZAL 10000/BGEZAL 10001, J 000010, JAL 000011, SPECIAL 000000 with funct JR 001000/JALR 001001.
REQ-025 Conditional branch taken = cmp_taken; J/JAL/JR/JALR always taken.
REQ-026 Branch target = id_pc+4 + (sign_extend(id_imm)<<2), 32-bit wrap-around.
REQ-027 J/JAL target = {(id_pc+4)[31:28], id_index, 2'b00}; JR/JALR target = rs_val, unmodified.
REQ-028 BLTZAL/BGEZAL assert link_wen regardless of taken.
REQ-029 FSM states: RUN, PEND; pend_target register 32 bits.
REQ-030 Next-PC priority: rst > flush > stall_if > PEND > br_taken > pc+4.
REQ-031 flush: pc<=redirect_pc, state<=RUN, next_in_ds<=0, pending target discarded, even if stall_if=1.
REQ-032 stall_if=1 and br_taken=1 in RUN: pc held, pend_target<=target, state<=PEND.
REQ-033 stall_if=1 in PEND: pc and pend_target held; new br_taken ignored.
REQ-034 stall_if=0 in PEND: pc<=pend_target, state<=RUN.
REQ-035 stall_if=0 in RUN: pc<=target if br_taken else pc+4 (wraps 32'hFFFFFFFC->0).
REQ-036 next_in_ds<=1 when id_fire and any control instruction (taken or not); <=0 when id_fire otherwise; held when id_fire=0.
REQ-037 Taken-branch latency: target appears on pc one cycle after br_taken (delay slot already fetched).
REQ-038 Misaligned JR target loaded into pc unchanged; pc_adel flags it; no internal trap.

Reset
REQ-039 On rst: pc=RESET_PC, state=RUN, pend_target=0, next_in_ds=0; rst overrides flush and stall_if.
REQ-040 Combinational outputs follow inputs during reset; no other retained state.

Structure
REQ-041 Opcode, REGIMM rt, funct codes and RESET_PC default reside in shared defines.h.
REQ-042 One sub-module br_target_gen: combinational target/link computation from id_* and rs_val.
REQ-043 FSM and PC register in pc_branch_ctrl only.

Verification
REQ-044 rst 1 cycle then 3 idle cycles -> pc BFC00000, BFC00004, BFC00008, BFC0000C.
REQ-045 BEQ id_pc=BFC00010, imm=FFFE, cmp_taken=1, id_fire=1 -> br_taken=1, next pc=BFC0000C, next_in_ds=1.
REQ-046 JAL id_pc=80001000, index=0000040 -> pc=80000100, link_wen=1, link_reg=31, link_addr=80001008.
REQ-047 JR rs_val=80002000 with stall_if=1 two cycles -> pc held, state PEND; stall drops -> pc=80002000.
REQ-048 flush redirect_pc=BFC00380 with stall_if=1 and PEND -> pc=BFC00380, state RUN, next_in_ds=0.
REQ-049 BNE cmp_taken=0 -> br_taken=0, pc=pc+4, next_in_ds=1; JR rs_val=80000002 -> pc_adel=1.

Source files
------------

// File: rtl/pc_branch_ctrl_pkg.sv
// pc_branch_ctrl_pkg: shared opcode/subtype codes, reset vector and FSM state type
package pc_branch_ctrl_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC00000;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    typedef enum logic {RUN, PEND} state_t;
endpackage

// File: rtl/pc_branch_ctrl_br_target_gen.sv
// pc_branch_ctrl_br_target_gen: decodes the ID instruction into control-transfer info
// in : id_op/id_rt/id_rd/id_funct/id_imm/id_index/id_pc, rs_val, cmp_taken
// out: is_ctrl (any control instr), taken, target, link, link_reg, link_addr
module pc_branch_ctrl_br_target_gen
    import pc_branch_ctrl_pkg::*;
(
    input  logic [5:0]  id_op,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [5:0]  id_funct,
    input  logic [15:0] id_imm,
    input  logic [25:0] id_index,
    input  logic [31:0] id_pc,
    input  logic [31:0] rs_val,
    input  logic        cmp_taken,
    output logic        is_ctrl,
    output logic        taken,
    output logic [31:0] target,
    output logic        link,
    output logic [4:0]  link_reg,
    output logic [31:0] link_addr
);
    logic [31:0] pc4;
    logic regimm_br, is_br, is_j, is_jr;
    assign pc4 = id_pc + 32'd4;
    assign regimm_br = id_op == OP_REGIMM &&
        (id_rt == RT_BLTZ || id_rt == RT_BGEZ || id_rt == RT_BLTZAL || id_rt == RT_BGEZAL);
    assign is_br = id_op == OP_BEQ || id_op == OP_BNE || id_op == OP_BLEZ || id_op == OP_BGTZ || regimm_br;
    assign is_j = id_op == OP_J || id_op == OP_JAL;
    assign is_jr = id_op == OP_SPECIAL && (id_funct == FN_JR || id_funct == FN_JALR);
    assign is_ctrl = is_br | is_j | is_jr;
    assign taken = is_j | is_jr | (is_br & cmp_taken);
    assign target = is_jr ? rs_val
                  : is_j  ? {pc4[31:28], id_index, 2'b00}
                  : pc4 + {{14{id_imm[15]}}, id_imm, 2'b00};
    // rt[4] distinguishes the linking REGIMM forms; they link even when not taken
    assign link = id_op == OP_JAL || (is_jr && id_funct == FN_JALR) || (regimm_br && id_rt[4]);
    assign link_reg = is_jr ? id_rd : 5'd31;
    assign link_addr = id_pc + 32'd8;
endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: fetch PC register with branch/jump redirect, stall pending and flush
// in : clk, rst, stall_if, id_fire, flush, redirect_pc, id_* fields, rs_val, cmp_taken
// out: pc, pc_adel, br_taken, link_wen, link_reg, link_addr, next_in_ds
module pc_branch_ctrl
    import pc_branch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        id_fire,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic [5:0]  id_op,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [5:0]  id_funct,
    input  logic [15:0] id_imm,
    input  logic [25:0] id_index,
    input  logic [31:0] id_pc,
    input  logic [31:0] rs_val,
    input  logic        cmp_taken,
    output logic [31:0] pc,
    output logic        pc_adel,
    output logic        br_taken,
    output logic        link_wen,
    output logic [4:0]  link_reg,
    output logic [31:0] link_addr,
    output logic        next_in_ds
);
    state_t st, st_n;
    logic [31:0] pend_target, pt_n, pc_n, target;
    logic is_ctrl, taken, link, ds_n;
    pc_branch_ctrl_br_target_gen u_tgt (
        .id_op(id_op), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
        .id_imm(id_imm), .id_index(id_index), .id_pc(id_pc), .rs_val(rs_val),
        .cmp_taken(cmp_taken), .is_ctrl(is_ctrl), .taken(taken), .target(target),
        .link(link), .link_reg(link_reg), .link_addr(link_addr)
    );
    assign br_taken = id_fire & taken;
    assign link_wen = id_fire & link;
    assign pc_adel = pc[1:0] != 2'b00;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            st <= RUN;
            pend_target <= '0;
            next_in_ds <= 1'b0;
        end else begin
            pc <= pc_n;
            st <= st_n;
            pend_target <= pt_n;
            next_in_ds <= ds_n;
        end
    end
    // A taken branch seen while IF is stalled is parked in pend_target and
    // applied on the first unstalled cycle; later branches are ignored meanwhile.
    always_comb begin
        pc_n = pc;
        st_n = st;
        pt_n = pend_target;
        if (flush) begin
            pc_n = redirect_pc;
            st_n = RUN;
        end else if (stall_if) begin
            if (st == RUN && br_taken) begin
                pt_n = target;
                st_n = PEND;
            end
        end else if (st == PEND) begin
            pc_n = pend_target;
            st_n = RUN;
        end else begin
            pc_n = br_taken ? target : pc + 32'd4;
        end
        ds_n = flush ? 1'b0 : id_fire ? is_ctrl : next_in_ds;
    end
endmodule
